// File: rtl/bus_demux4.sv
// Single-master to four-slave bus demultiplexer. m_addr[31:30] picks the slave, and a
// per-transaction wait counter turns a missing acknowledge into an error response.
module bus_demux4 #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic [31:0] m_rdata,
    output logic        m_ack,
    output logic        m_err,
    output logic [3:0]  s_sel,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata0,
    input  logic [31:0] s_rdata1,
    input  logic [31:0] s_rdata2,
    input  logic [31:0] s_rdata3,
    input  logic [3:0]  s_ack
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [7:0] CNT_MAX  = 8'(TIMEOUT);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_idx;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [3:0]  r_sel;
    logic        r_ack;
    logic        r_err;
    logic        w_hit;
    logic        w_timeout;
    logic [31:0] w_slave_rdata;

    // Only the addressed slave's acknowledge and data are ever looked at.
    always_comb begin
        w_hit         = s_ack[r_idx];
        w_timeout     = (r_cnt >= CNT_LAST);
        w_slave_rdata = s_rdata0;
        case (r_idx)
            2'd0:    w_slave_rdata = s_rdata0;
            2'd1:    w_slave_rdata = s_rdata1;
            2'd2:    w_slave_rdata = s_rdata2;
            default: w_slave_rdata = s_rdata3;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (m_req) w_next = ACCESS;
            ACCESS:  if (w_hit || w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // An ack in the final ACCESS cycle is checked before the timeout, so it wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= 2'd0;
            r_cnt   <= 8'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_sel   <= 4'b0000;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sel <= 4'b0000;
                    if (m_req) begin
                        r_we    <= m_we;
                        r_addr  <= m_addr;
                        r_wdata <= m_wdata;
                        r_idx   <= m_addr[31:30];
                        r_cnt   <= 8'd0;
                        r_sel   <= 4'b0001 << m_addr[31:30];
                    end
                end
                ACCESS: begin
                    if (r_cnt < CNT_MAX) r_cnt <= r_cnt + 8'd1;
                    if (w_hit) begin
                        if (!r_we) r_rdata <= w_slave_rdata;
                        r_sel <= 4'b0000;
                        r_ack <= 1'b1;
                    end else if (w_timeout) begin
                        r_rdata <= 32'h0;
                        r_sel   <= 4'b0000;
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                default: begin
                    r_sel <= 4'b0000;
                end
            endcase
        end
    end

    assign m_rdata = r_rdata;
    assign m_ack   = r_ack;
    assign m_err   = r_err;
    assign s_sel   = r_sel;
    assign s_we    = r_we;
    assign s_addr  = r_addr;
    assign s_wdata = r_wdata;

endmodule
